// File: rtl/counter_pkg.sv
// Shared types and constants for the sequenced up/down counter.
// Imported by the sequencer FSM and its step counter datapath.
package counter_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A requested pass count of zero still runs one pass.
  function automatic logic [4:0] eff_reps(input logic [3:0] r);
    return (r == 4'd0) ? 5'd1 : {1'b0, r};
  endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable up/down counter: load_val on load, else +/-1 per cycle when en, one-cycle latency.
// No backpressure; load has priority over en, reset over both.
module step_counter
  import counter_pkg::*;
#(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [bits-1:0] load_val,
  input  logic            en,
  input  logic            select,
  output logic [bits-1:0] count
);

  localparam logic [bits-1:0] ONE = {{(bits-1){1'b0}}, 1'b1};

  logic [bits-1:0] count_d;
  logic [bits-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = (select == DIR_UP) ? (count_q + ONE) : (count_q - ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Sequenced counter runs: start/busy/done handshake, N passes start->end value with pause/abort.
// All outputs registered; start is ignored (not queued) while busy, abort beats pause.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            select,
  input  logic [bits-1:0] target,
  input  logic [3:0]      reps,
  input  logic            pause,
  input  logic            abort,
  output logic [bits-1:0] count,
  output logic [3:0]      pass_idx,
  output logic            busy,
  output logic            done
);

  seq_state_t state_d, state_q;

  logic            sel_d, sel_q;
  logic [bits-1:0] target_d, target_q;
  logic [3:0]      reps_d, reps_q;
  logic [3:0]      pass_idx_d, pass_idx_q;
  logic            busy_d, busy_q;
  logic            done_d, done_q;

  logic            cnt_load;
  logic            cnt_en;
  logic [bits-1:0] start_val;
  logic [bits-1:0] end_val;
  logic            at_end;
  logic            last_pass;

  assign start_val = (sel_q == DIR_UP) ? '0 : target_q;
  assign end_val   = (sel_q == DIR_UP) ? target_q : '0;
  assign at_end    = (count == end_val);
  assign last_pass = (({1'b0, pass_idx_q} + 5'd1) >= eff_reps(reps_q));

  step_counter #(
    .bits(bits)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(start_val),
    .en      (cnt_en),
    .select  (sel_q),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      target_q   <= '0;
      reps_q     <= '0;
      pass_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      target_q   <= target_d;
      reps_q     <= reps_d;
      pass_idx_q <= pass_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort)          state_d = IDLE;
        else if (pause)     state_d = HOLD;
        else if (!at_end)   state_d = RUN;
        else if (!last_pass) state_d = LOAD;
        else                state_d = DONE;
      end
      HOLD: begin
        if (abort)       state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are computed from the next state so they are flop outputs aligned with state_q.
  always_comb begin
    sel_d      = sel_q;
    target_d   = target_q;
    reps_d     = reps_q;
    pass_idx_d = pass_idx_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d      = select;
          target_d   = target;
          reps_d     = reps;
          pass_idx_d = '0;
        end
      end
      LOAD: cnt_load = !abort;
      RUN: begin
        if (!abort && !pause) begin
          if (!at_end)         cnt_en = 1'b1;
          else if (!last_pass) pass_idx_d = pass_idx_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign pass_idx = pass_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed checks of counter_sequencer runs, pause/abort, edge cases and reset.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       select = 1'b0;
  logic [3:0] target = 4'd0;
  logic [3:0] reps = 4'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic [3:0] pass_idx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.bits(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .select  (select),
    .target  (target),
    .reps    (reps),
    .pause   (pause),
    .abort   (abort),
    .count   (count),
    .pass_idx(pass_idx),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One active edge, then park on the falling edge for driving and sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a start request; returns just after E0.
  task automatic launch(input logic s, input logic [3:0] t, input logic [3:0] r);
    select = s;
    target = t;
    reps   = r;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] dn_cnt [10];
    logic [3:0] dn_pass[10];
    int         pulses;

    dn_cnt  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    dn_pass = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};

    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_pass", pass_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Up run, target 5
    launch(1'b1, 4'd5, 4'd1);
    chk("up_busy_e0", busy, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("up_count_e%0d", k), count, k - 1);
      chk($sformatf("up_done_e%0d", k), done, 0);
    end
    tick();
    chk("up_done_e7", done, 1);
    chk("up_busy_e7", busy, 1);
    tick();
    chk("up_done_e8", done, 0);
    chk("up_busy_e8", busy, 0);
    chk("up_count_hold", count, 5);

    // Down run, two passes
    launch(1'b0, 4'd3, 4'd2);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("dn_count_e%0d", k + 1), count, dn_cnt[k]);
      chk($sformatf("dn_pass_e%0d", k + 1), pass_idx, dn_pass[k]);
      if (done) pulses++;
    end
    chk("dn_done_e10", done, 1);
    tick();
    if (done) pulses++;
    chk("dn_busy_e11", busy, 0);
    chk("dn_pulses", pulses, 1);

    // Pause for 3 cycles at count 4, target 9
    launch(1'b1, 4'd9, 4'd1);
    for (int k = 1; k <= 5; k++) tick();
    chk("pz_count_e5", count, 4);
    pause = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      tick();
      chk($sformatf("pz_hold_e%0d", k), count, 4);
    end
    pause = 1'b0;
    tick();
    chk("pz_hold_e9", count, 4);
    for (int k = 10; k <= 14; k++) begin
      tick();
      chk($sformatf("pz_count_e%0d", k), count, k - 5);
      chk($sformatf("pz_nodone_e%0d", k), done, 0);
    end
    tick();
    chk("pz_done_e15", done, 1);
    tick();
    chk("pz_busy_e16", busy, 0);

    // Abort with pause at count 6, target 12
    launch(1'b1, 4'd12, 4'd1);
    for (int k = 1; k <= 7; k++) tick();
    chk("ab_count_e7", count, 6);
    abort = 1'b1;
    pause = 1'b1;
    tick();
    abort = 1'b0;
    pause = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_count", count, 6);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) pulses++;
      tick();
    end
    chk("ab_no_done", pulses, 0);
    chk("ab_count_late", count, 6);

    // Zero target, zero reps
    launch(1'b1, 4'd0, 4'd0);
    tick();
    chk("z_count_e1", count, 0);
    chk("z_done_e1", done, 0);
    tick();
    chk("z_done_e2", done, 1);
    tick();
    chk("z_done_e3", done, 0);
    chk("z_busy_e3", busy, 0);

    // Full-scale up run, no wrap
    launch(1'b1, 4'd15, 4'd1);
    for (int k = 1; k <= 16; k++) tick();
    chk("ff_count_e16", count, 15);
    tick();
    chk("ff_done_e17", done, 1);
    chk("ff_count_e17", count, 15);
    tick();
    chk("ff_count_e18", count, 15);
    chk("ff_busy_e18", busy, 0);

    // Start while busy is ignored
    launch(1'b1, 4'd4, 4'd1);
    tick();
    tick();
    chk("sb_count_e2", count, 1);
    select = 1'b0;
    target = 4'd9;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("sb_count_e3", count, 2);
    tick();
    tick();
    chk("sb_count_e5", count, 4);
    tick();
    chk("sb_done_e6", done, 1);
    chk("sb_count_e6", count, 4);
    tick();
    chk("sb_busy_e7", busy, 0);

    // Reset mid-run during second pass
    launch(1'b1, 4'd2, 4'd3);
    for (int k = 1; k <= 6; k++) tick();
    chk("mr_count_e6", count, 1);
    chk("mr_pass_e6", pass_idx, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_count", count, 0);
    chk("mr_pass", pass_idx, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    launch(1'b1, 4'd1, 4'd1);
    chk("mr_busy_e0", busy, 1);
    tick();
    tick();
    chk("mr_count_e2", count, 1);
    tick();
    chk("mr_done_e3", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
